uart_tx_periph: RTL

//  Memory-mapped UART transmitter hung on the picorv32 native memory bus.

---
 rtl/uart_tx_periph.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter for the picorv32 native bus.
// CPU bytes are queued in a circular FIFO and serialised LSB first by a small
// IDLE/START/DATA/STOP state machine. Registers: 0x0 TXDATA, 0x4 STATUS.
module uart_tx_periph #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic [3:0]  mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_tx,
    output logic        busy
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int BIT_W   = $clog2(DIVISOR);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FILL_W  = PTR_W + 1;
    localparam logic [BIT_W-1:0]  DIV_LAST = BIT_W'(DIVISOR - 1);
    localparam logic [FILL_W-1:0] DEPTH_C  = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   timer_q, timer_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         fifo_mem [FIFO_DEPTH];

    logic               sel_s;
    logic               push_req_s;
    logic               push_s;
    logic               pop_s;
    logic               clr_ovf_s;
    logic [31:0]        status_s;
    logic               unused_ok_s;

    assign unused_ok_s = ^{mem_wdata[31:8], mem_addr[1:0]};

    // Bus decode: one acknowledge per request; done_q blocks re-acks while valid stays high.
    always_comb begin
        sel_s      = enable & mem_valid & ~ready_q & ~done_q;
        push_req_s = sel_s & (mem_addr[3:2] == 2'd0) & mem_wstrb[0];
        clr_ovf_s  = sel_s & (mem_addr[3:2] == 2'd1) & mem_wstrb[0] & mem_wdata[3];
        pop_s      = (state_q == S_IDLE) & (fill_q != {FILL_W{1'b0}});
        push_s     = push_req_s & ((fill_q != DEPTH_C) | pop_s);
        ready_d    = sel_s;
        done_d     = mem_valid & (done_q | sel_s);
        status_s   = 32'd0;
        status_s[0] = (fill_q == DEPTH_C);
        status_s[1] = (fill_q == {FILL_W{1'b0}});
        status_s[2] = (state_q != S_IDLE);
        status_s[3] = ovf_q;
        status_s[8 +: FILL_W] = fill_q;
        if (sel_s && (mem_wstrb == 4'd0) && (mem_addr[3:2] == 2'd1)) begin
            rdata_d = status_s;
        end else begin
            rdata_d = 32'd0;
        end
    end

    // FIFO pointer, fill-count and sticky overflow next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else if (push_req_s && !push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit FSM next-state; the line level is computed from the next state so it is registered.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    timer_d = {BIT_W{1'b0}};
                    state_d = S_START;
                end else begin
                    timer_d = {BIT_W{1'b0}};
                end
            end
            S_START: begin
                if (timer_q == DIV_LAST) begin
                    timer_d = {BIT_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + BIT_W'(1);
                end
            end
            S_DATA: begin
                if (timer_q == DIV_LAST) begin
                    timer_d = {BIT_W{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + BIT_W'(1);
                end
            end
            S_STOP: begin
                if (timer_q == DIV_LAST) begin
                    timer_d = {BIT_W{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + BIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = {BIT_W{1'b0}};
            end
        endcase
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (fill_d != {FILL_W{1'b0}}) | (state_d != S_IDLE);
    end

    // State, FIFO bookkeeping and bus response registers; reset aborts any frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= {BIT_W{1'b0}};
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 32'd0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            fill_q   <= {FILL_W{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign uart_tx   = tx_q;
    assign busy      = busy_q;
endmodule
